// File: rtl/axi_mwr_tlp_packer.sv
// axi_mwr_tlp_packer
// Takes one AXI4 write burst (AW + W), buffers up to MAX_BEATS beats and
// emits a single PCIe Memory-Write TLP: header fields plus a flat payload.
// The B response is returned once the TLP has been accepted downstream.
// Illegal bursts are drained without emitting a TLP and answered with SLVERR.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   aw*_i / awready_o   AXI write-address channel
//   w*_i  / wready_o    AXI write-data channel
//   b*_o  / bready_i    AXI write-response channel
//   cfg_req_id_i/tc_i   requester ID and traffic class for the header
//   tlp_*_o / tlp_ready_i  TLP header + payload, valid/ready handshake
module axi_mwr_tlp_packer #(
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned MAX_BEATS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ID_W-1:0]             awid_i,
  input  logic [ADDR_W-1:0]           awaddr_i,
  input  logic [7:0]                  awlen_i,
  input  logic [2:0]                  awsize_i,
  input  logic [1:0]                  awburst_i,
  input  logic                        awvalid_i,
  output logic                        awready_o,
  input  logic [DATA_W-1:0]           wdata_i,
  input  logic [DATA_W/8-1:0]         wstrb_i,
  input  logic                        wlast_i,
  input  logic                        wvalid_i,
  output logic                        wready_o,
  output logic [ID_W-1:0]             bid_o,
  output logic [1:0]                  bresp_o,
  output logic                        bvalid_o,
  input  logic                        bready_i,
  input  logic [15:0]                 cfg_req_id_i,
  input  logic [2:0]                  cfg_tc_i,
  output logic                        tlp_valid_o,
  input  logic                        tlp_ready_i,
  output logic [2:0]                  tlp_fmt_o,
  output logic [4:0]                  tlp_type_o,
  output logic [2:0]                  tlp_tc_o,
  output logic [9:0]                  tlp_length_o,
  output logic [15:0]                 tlp_req_id_o,
  output logic [3:0]                  tlp_first_be_o,
  output logic [3:0]                  tlp_last_be_o,
  output logic [ADDR_W-1:0]           tlp_addr_o,
  output logic [DATA_W*MAX_BEATS-1:0] tlp_data_o
);

  localparam int unsigned STRB_W      = DATA_W / 8;
  localparam int unsigned DW_PER_BEAT = DATA_W / 32;
  localparam int unsigned BUF_W       = DATA_W * MAX_BEATS;
  localparam int unsigned SLOT_W      = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam int unsigned SIZE_LOG2   = $clog2(STRB_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_SEND = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic awready_q, awready_d;
  logic wready_q, wready_d;
  logic tlp_valid_q, tlp_valid_d;
  logic bvalid_q, bvalid_d;

  logic [ID_W-1:0]   id_q;
  logic [7:0]        len_q;
  logic [7:0]        cnt_q;
  logic              err_q;
  logic [2:0]        fmt_q;
  logic [2:0]        tc_q;
  logic [9:0]        length_q;
  logic [15:0]       req_id_q;
  logic [3:0]        first_be_q;
  logic [3:0]        last_be_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BUF_W-1:0]  buf_q;

  logic aw_hs_c, w_hs_c, tlp_hs_c, b_hs_c;
  logic aw_err_c, beat_err_c, is_4dw_c;
  logic [SLOT_W-1:0] slot_c;
  logic [9:0]        length_c;

  assign aw_hs_c  = awvalid_i & awready_q;
  assign w_hs_c   = wvalid_i & wready_q;
  assign tlp_hs_c = tlp_valid_q & tlp_ready_i;
  assign b_hs_c   = bvalid_q & bready_i;

  // Burst legality at AW time: INCR only, full-width beats, fits in buffer.
  assign aw_err_c = (awburst_i != 2'b01) ||
                    (awsize_i != 3'(SIZE_LOG2)) ||
                    (9'(awlen_i) >= 9'(MAX_BEATS));

  // wlast must coincide exactly with the beat numbered len.
  assign beat_err_c = wlast_i ? (cnt_q != len_q) : (cnt_q == len_q);

  assign slot_c   = SLOT_W'(cnt_q);
  assign length_c = 10'((32'(awlen_i) + 32'd1) * DW_PER_BEAT);

  // 4DW header only when the address has bits set above bit 31.
  generate
    if (ADDR_W > 32) begin : g_addr64
      assign is_4dw_c = |awaddr_i[ADDR_W-1:32];
    end else begin : g_addr32
      assign is_4dw_c = 1'b0;
    end
  endgenerate

  // State register and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      tlp_valid_q <= 1'b0;
      bvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      tlp_valid_q <= tlp_valid_d;
      bvalid_q    <= bvalid_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (aw_hs_c) state_d = S_DATA;
      S_DATA: if (w_hs_c && wlast_i) state_d = (err_q || beat_err_c) ? S_RESP : S_SEND;
      S_SEND: if (tlp_hs_c) state_d = S_RESP;
      S_RESP: if (b_hs_c) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state so the handshake flops line up with state_q.
  always_comb begin
    awready_d   = 1'b0;
    wready_d    = 1'b0;
    tlp_valid_d = 1'b0;
    bvalid_d    = 1'b0;
    unique case (state_d)
      S_IDLE:  awready_d   = 1'b1;
      S_DATA:  wready_d    = 1'b1;
      S_SEND:  tlp_valid_d = 1'b1;
      S_RESP:  bvalid_d    = 1'b1;
      default: awready_d   = 1'b0;
    endcase
  end

  // Burst context, header fields and payload buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_q       <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      fmt_q      <= '0;
      tc_q       <= '0;
      length_q   <= '0;
      req_id_q   <= '0;
      first_be_q <= '0;
      last_be_q  <= '0;
      addr_q     <= '0;
      buf_q      <= '0;
    end else begin
      if (aw_hs_c) begin
        id_q       <= awid_i;
        len_q      <= awlen_i;
        cnt_q      <= '0;
        err_q      <= aw_err_c;
        fmt_q      <= is_4dw_c ? 3'b011 : 3'b010;
        tc_q       <= cfg_tc_i;
        length_q   <= length_c;
        req_id_q   <= cfg_req_id_i;
        first_be_q <= '0;
        last_be_q  <= '0;
        addr_q     <= {awaddr_i[ADDR_W-1:2], 2'b00};
        buf_q      <= '0;
      end
      if (w_hs_c) begin
        cnt_q <= cnt_q + 8'd1;
        err_q <= err_q | beat_err_c;
        // Once in error, beats are only drained; cnt never exceeds len here.
        if (!err_q) begin
          buf_q[DATA_W*int'(slot_c) +: DATA_W] <= wdata_i;
          if (cnt_q == 8'd0) first_be_q <= wstrb_i[3:0];
          last_be_q <= (length_q == 10'd1) ? 4'b0000 : wstrb_i[STRB_W-1 -: 4];
        end
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{awaddr_i[1:0], wstrb_i};

  assign awready_o      = awready_q;
  assign wready_o       = wready_q;
  assign tlp_valid_o    = tlp_valid_q;
  assign bvalid_o       = bvalid_q;
  assign bid_o          = id_q;
  assign bresp_o        = {err_q, 1'b0};
  assign tlp_fmt_o      = fmt_q;
  assign tlp_type_o     = 5'b00000;
  assign tlp_tc_o       = tc_q;
  assign tlp_length_o   = length_q;
  assign tlp_req_id_o   = req_id_q;
  assign tlp_first_be_o = first_be_q;
  assign tlp_last_be_o  = last_be_q;
  assign tlp_addr_o     = addr_q;
  assign tlp_data_o     = buf_q;

endmodule

// File: tb/tb_axi_mwr_tlp_packer.sv
// Testbench for axi_mwr_tlp_packer: drives AXI bursts, compares the TLP and
// B response against a transaction-level reference model.
module tb_axi_mwr_tlp_packer;

  localparam int unsigned DATA_W    = 128;
  localparam int unsigned ADDR_W    = 64;
  localparam int unsigned ID_W      = 4;
  localparam int unsigned MAX_BEATS = 4;
  localparam int unsigned BUF_W     = DATA_W * MAX_BEATS;
  localparam int unsigned HDR_W     = 3 + 5 + 3 + 10 + 16 + 4 + 4 + ADDR_W;

  logic                clk = 1'b0;
  logic                rst;
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid, awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast, wvalid, wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid, bready;
  logic [15:0]         cfg_req_id;
  logic [2:0]          cfg_tc;
  logic                tlp_valid, tlp_ready;
  logic [2:0]          tlp_fmt;
  logic [4:0]          tlp_type;
  logic [2:0]          tlp_tc;
  logic [9:0]          tlp_length;
  logic [15:0]         tlp_req_id;
  logic [3:0]          tlp_first_be, tlp_last_be;
  logic [ADDR_W-1:0]   tlp_addr;
  logic [BUF_W-1:0]    tlp_data;

  axi_mwr_tlp_packer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .MAX_BEATS(MAX_BEATS)
  ) dut (
    .clk(clk), .rst(rst),
    .awid_i(awid), .awaddr_i(awaddr), .awlen_i(awlen), .awsize_i(awsize),
    .awburst_i(awburst), .awvalid_i(awvalid), .awready_o(awready),
    .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast), .wvalid_i(wvalid),
    .wready_o(wready),
    .bid_o(bid), .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
    .cfg_req_id_i(cfg_req_id), .cfg_tc_i(cfg_tc),
    .tlp_valid_o(tlp_valid), .tlp_ready_i(tlp_ready),
    .tlp_fmt_o(tlp_fmt), .tlp_type_o(tlp_type), .tlp_tc_o(tlp_tc),
    .tlp_length_o(tlp_length), .tlp_req_id_o(tlp_req_id),
    .tlp_first_be_o(tlp_first_be), .tlp_last_be_o(tlp_last_be),
    .tlp_addr_o(tlp_addr), .tlp_data_o(tlp_data)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  logic [DATA_W-1:0] bd [8];
  logic [15:0]       bs [8];

  function automatic logic [HDR_W-1:0] dut_hdr();
    return {tlp_fmt, tlp_type, tlp_tc, tlp_length, tlp_req_id,
            tlp_first_be, tlp_last_be, tlp_addr};
  endfunction

  // One complete burst: drive AW/W, then check TLP (or its absence) and B.
  task automatic run_txn(input logic [63:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input int nb, input int hold, input bit overlap,
                         input bit fixed_pat);
    logic [ID_W-1:0]  id;
    logic [15:0]      req;
    logic [2:0]       tc;
    bit               exp_err;
    logic [BUF_W-1:0] exp_data;
    logic [HDR_W-1:0] exp_hdr;
    logic [2:0]       exp_fmt;
    int               t;
    int               d;
    id  = ID_W'($urandom);
    req = 16'($urandom);
    tc  = 3'($urandom);
    for (int k = 0; k < 8; k++) begin
      bd[k] = fixed_pat ? {4{32'h01234567}} : {$urandom, $urandom, $urandom, $urandom};
      bs[k] = fixed_pat ? 16'hFFFF : 16'($urandom);
    end
    // Reference model: a burst is good only if legal at AW and wlast lands on beat len.
    exp_err = (burst != 2'b01) || (size != 3'd4) ||
              (int'(len) + 1 > int'(MAX_BEATS)) || (nb != int'(len) + 1);
    exp_data = '0;
    exp_hdr  = '0;
    if (!exp_err) begin
      for (int i = 0; i <= int'(len); i++) exp_data[i*DATA_W +: DATA_W] = bd[i];
      exp_fmt = (addr[63:32] == 32'd0) ? 3'b010 : 3'b011;
      exp_hdr = {exp_fmt, 5'b00000, tc, 10'((int'(len) + 1) * 4), req,
                 bs[0][3:0], bs[len][15:12], addr & ~64'h3};
    end

    @(negedge clk);
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
    cfg_req_id = req; cfg_tc = tc; awvalid = 1'b1;
    if (overlap) begin
      wdata = bd[0]; wstrb = bs[0]; wlast = (nb == 1); wvalid = 1'b1;
    end
    t = 0;
    while (awready !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    if (t == 20) begin
      errs++; $display("FAIL aw_timeout: awready=%b required 1", awready);
    end
    vecs++;
    @(negedge clk);
    awvalid = 1'b0;
    cfg_req_id = 16'($urandom);
    cfg_tc = 3'($urandom);

    for (int k = 0; k < nb; k++) begin
      wdata = bd[k]; wstrb = bs[k]; wlast = (k == nb - 1); wvalid = 1'b1;
      t = 0;
      while (wready !== 1'b1 && t < 20) begin @(negedge clk); t++; end
      if (t == 20) begin
        errs++; vecs++; $display("FAIL w_timeout: beat %0d wready=%b required 1", k, wready);
      end
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;

    if (!exp_err) begin
      for (int c = 0; c <= hold; c++) begin
        vecs++;
        if ({tlp_valid, bvalid} !== 2'b10) begin
          errs++; $display("FAIL tlp_valid: cyc %0d valid,bvalid=%b%b required 10", c, tlp_valid, bvalid);
        end
        vecs++;
        if (dut_hdr() !== exp_hdr) begin
          errs++; $display("FAIL tlp_hdr: cyc %0d got %h required %h", c, dut_hdr(), exp_hdr);
        end
        vecs++;
        if (tlp_data !== exp_data) begin
          errs++; $display("FAIL tlp_data: cyc %0d got %h required %h", c, tlp_data, exp_data);
        end
        if (c == hold) tlp_ready = 1'b1;
        @(negedge clk);
      end
      tlp_ready = 1'b0;
    end

    d = $urandom_range(0, 3);
    for (int c = 0; c <= d; c++) begin
      vecs++;
      if ({bvalid, tlp_valid, bid, bresp} !== {1'b1, 1'b0, id, exp_err ? 2'b10 : 2'b00}) begin
        errs++;
        $display("FAIL bresp: cyc %0d bvalid=%b tlp_valid=%b bid=%h bresp=%b required 1 0 %h %b",
                 c, bvalid, tlp_valid, bid, bresp, id, exp_err ? 2'b10 : 2'b00);
      end
      if (c == d) bready = 1'b1;
      @(negedge clk);
    end
    bready = 1'b0;
    vecs++;
    if ({bvalid, awready} !== 2'b01) begin
      errs++; $display("FAIL b_done: bvalid,awready=%b%b required 01", bvalid, awready);
    end
  endtask

  task automatic check_all_zero(input string tag);
    vecs++;
    if ({awready, wready, bvalid, bid, bresp, tlp_valid} !== '0 || dut_hdr() !== '0) begin
      errs++;
      $display("FAIL %s_ctrl: aw=%b w=%b b=%b bid=%h bresp=%b tv=%b hdr=%h required all 0",
               tag, awready, wready, bvalid, bid, bresp, tlp_valid, dut_hdr());
    end
    vecs++;
    if (tlp_data !== '0) begin
      errs++; $display("FAIL %s_data: got %h required 0", tag, tlp_data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    vecs++;
    if (awready !== 1'b1) begin
      errs++; $display("FAIL reset_idle: awready=%b required 1", awready);
    end
  endtask

  task automatic test_basic();
    run_txn(64'h0, 8'd1, 3'd4, 2'b01, 2, 0, 1'b0, 1'b1);
  endtask

  task automatic test_4dw();
    run_txn(64'h1_0000_0020, 8'd0, 3'd4, 2'b01, 1, 1, 1'b0, 1'b0);
  endtask

  task automatic test_fixed_burst();
    run_txn(64'h1000, 8'd1, 3'd4, 2'b00, 2, 0, 1'b0, 1'b0);
  endtask

  task automatic test_early_wlast();
    run_txn(64'h2000, 8'd3, 3'd4, 2'b01, 2, 0, 1'b0, 1'b0);
    run_txn(64'h3000, 8'd3, 3'd4, 2'b01, 4, 0, 1'b0, 1'b0);
  endtask

  task automatic test_missing_wlast();
    run_txn(64'h4000, 8'd1, 3'd4, 2'b01, 3, 0, 1'b0, 1'b0);
    run_txn(64'h5000, 8'd2, 3'd4, 2'b01, 3, 0, 1'b0, 1'b0);
  endtask

  task automatic test_oversize();
    run_txn(64'h6000, 8'd4, 3'd4, 2'b01, 5, 0, 1'b0, 1'b0);
    run_txn(64'h6100, 8'd0, 3'd3, 2'b01, 1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_txn(64'h7_0000_0104, 8'd2, 3'd4, 2'b01, 3, 20, 1'b0, 1'b0);
  endtask

  task automatic test_overlap();
    run_txn(64'h8000, 8'd1, 3'd4, 2'b01, 2, 0, 1'b1, 1'b0);
    run_txn(64'h8100, 8'd0, 3'd4, 2'b01, 1, 0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    int t;
    @(negedge clk);
    awid = 4'h5; awaddr = 64'h9000; awlen = 8'd2; awsize = 3'd4; awburst = 2'b01;
    awvalid = 1'b1;
    t = 0;
    while (awready !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    @(negedge clk);
    awvalid = 1'b0;
    wdata = {4{$urandom}}; wstrb = 16'hFFFF; wlast = 1'b0; wvalid = 1'b1;
    t = 0;
    while (wready !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    @(negedge clk);
    wvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("rst_mid");
    rst = 1'b0;
    @(negedge clk);
    run_txn(64'hA000, 8'd1, 3'd4, 2'b01, 2, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [63:0] a;
      logic [7:0]  l;
      logic [2:0]  s;
      logic [1:0]  b;
      int          nb;
      a  = {($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'd0, $urandom};
      l  = 8'($urandom_range(0, 4));
      s  = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'd4;
      b  = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b01;
      nb = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 6) : int'(l) + 1;
      run_txn(a, l, s, b, nb, $urandom_range(0, 3), 1'($urandom), 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    bready = 1'b0; tlp_ready = 1'b0; cfg_req_id = '0; cfg_tc = '0;
    test_reset();
    test_basic();
    test_4dw();
    test_fixed_burst();
    test_early_wlast();
    test_missing_wlast();
    test_oversize();
    test_backpressure();
    test_overlap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
